// File: rtl/inst_pkg.sv
// rtl/inst_pkg.sv - shared instruction format, field position and loader state definitions
package inst_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_RAW = 2'b11
  } fmt_e;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    WRITE = ST_WRITE,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/inst_field_pack.sv
// rtl/inst_field_pack.sv - combinational packing of MIPS instruction fields into a 32-bit word
module inst_field_pack
  import inst_pkg::*;
(
  input  logic [1:0]  fmt_i,
  input  logic [5:0]  opcode_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  input  logic [31:0] raw_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    case (fmt_e'(fmt_i))
      FMT_R: begin
        word_o[OP_LSB +: 6] = opcode_i;
        word_o[RS_LSB +: 5] = rs_i;
        word_o[RT_LSB +: 5] = rt_i;
        word_o[RD_LSB +: 5] = rd_i;
        word_o[SH_LSB +: 5] = shamt_i;
        word_o[5:0]         = funct_i;
      end
      FMT_I: begin
        word_o[OP_LSB +: 6] = opcode_i;
        word_o[RS_LSB +: 5] = rs_i;
        word_o[RT_LSB +: 5] = rt_i;
        word_o[15:0]        = imm_i;
      end
      FMT_J: begin
        word_o[OP_LSB +: 6] = opcode_i;
        word_o[25:0]        = target_i;
      end
      default: word_o = raw_i;
    endcase
  end

endmodule

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - streams packed instruction words into instruction memory at consecutive addresses
module inst_rom_loader
  import inst_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic [31:0]       raw,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full_err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_1  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_1 = ADDR_W'(1);

  state_e            state_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              full_q;
  logic              last_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic [31:0]       word_d;

  inst_field_pack u_pack (
    .fmt_i    (fmt),
    .opcode_i (opcode),
    .rs_i     (rs),
    .rt_i     (rt),
    .rd_i     (rd),
    .shamt_i  (shamt),
    .funct_i  (funct),
    .imm_i    (imm),
    .target_i (target),
    .raw_i    (raw),
    .word_o   (word_d)
  );

  assign count_d = count_q + CNT_1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mem_we_q <= 1'b0;
      addr_q   <= BASE;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
      last_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (start) begin
        state_q <= LOAD;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        full_q  <= 1'b0;
        count_q <= '0;
        addr_q  <= BASE;
      end else begin
        case (state_q)
          LOAD: begin
            if (in_valid) begin
              wdata_q  <= word_d;
              last_q   <= in_last;
              mem_we_q <= 1'b1;
              state_q  <= WRITE;
            end
          end
          WRITE: begin
            count_q <= count_d;
            addr_q  <= addr_q + ADDR_1;
            if (last_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (count_d == DEPTH) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              full_q  <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // An abort arriving during WRITE must keep the already-raised strobe off the memory bus.
  assign mem_we    = mem_we_q & ~start;
  assign in_ready  = (state_q == LOAD);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign full_err  = full_q;
  assign count     = count_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - directed self-checking bench for inst_rom_loader
module tb_inst_rom_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_last;
  logic          in_ready, mem_we, busy, done, full_err;
  logic [1:0]    fmt;
  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd, shamt;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic [31:0]   raw, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .target(target), .raw(raw),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .full_err(full_err), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"},    32'(mem_we),    32'd0);
    chk({tag, "_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_wdata"}, mem_wdata,      32'd0);
    chk({tag, "_rdy"},   32'(in_ready),  32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
    chk({tag, "_full"},  32'(full_err),  32'd0);
    chk({tag, "_count"}, 32'(count),     32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Presents one field set in LOAD and returns at the negedge of the following WRITE cycle.
  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                      input logic [31:0] rw, input logic lst);
    @(negedge clk);
    chk("ready_before_send", 32'(in_ready), 32'd1);
    fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
    imm = im; target = tg; raw = rw; in_last = lst; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  function automatic logic [31:0] model_pack(input logic [1:0] f, input logic [5:0] op,
      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg, input logic [31:0] rw);
    logic [31:0] w;
    case (f)
      2'b00: w = (32'(op) << 26) | (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | (32'(sh) << 6) | 32'(fn);
      2'b01: w = (32'(op) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
      2'b10: w = (32'(op) << 26) | 32'(tg);
      default: w = rw;
    endcase
    return w;
  endfunction

  initial begin
    logic [1:0]  f;
    logic [5:0]  op, fn;
    logic [4:0]  s, t, d, sh;
    logic [15:0] im;
    logic [25:0] tg;
    logic [31:0] rw, w;
    logic        lst;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    fmt = '0; opcode = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
    imm = '0; target = '0; raw = '0;
    #12;
    chk_reset("reset");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd0);

    // R-type
    pulse_start();
    chk("load_busy", 32'(busy), 32'd1);
    send(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hffff, 26'h3ffffff, 32'hdeadbeef, 1'b0);
    chk("r_we", 32'(mem_we), 32'd1);
    chk("r_addr", 32'(mem_addr), 32'd0);
    chk("r_wdata", mem_wdata, 32'h00221820);
    chk("r_ready_in_write", 32'(in_ready), 32'd0);

    // I then J with last
    pulse_start();
    chk("restart_count", 32'(count), 32'd0);
    send(2'b01, 6'h09, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3f, 16'h0005, 26'h3ffffff, 32'h0, 1'b0);
    chk("i_wdata", mem_wdata, 32'h24080005);
    chk("i_addr", 32'(mem_addr), 32'd0);
    send(2'b10, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hffff, 26'h10, 32'h0, 1'b1);
    chk("j_wdata", mem_wdata, 32'h08000010);
    chk("j_addr", 32'(mem_addr), 32'd1);
    @(negedge clk);
    chk("ij_done", 32'(done), 32'd1);
    chk("ij_busy", 32'(busy), 32'd0);
    chk("ij_count", 32'(count), 32'd2);
    chk("ij_full", 32'(full_err), 32'd0);
    chk("ij_we", 32'(mem_we), 32'd0);

    // Fill the 4-word memory without in_last
    pulse_start();
    chk("full_done_cleared", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send(2'b11, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'hA0000000 + 32'(i), 1'b0);
      chk("full_addr", 32'(mem_addr), 32'(i));
      chk("full_wdata", mem_wdata, 32'hA0000000 + 32'(i));
    end
    @(negedge clk);
    chk("full_err", 32'(full_err), 32'd1);
    chk("full_done", 32'(done), 32'd1);
    chk("full_count", 32'(count), 32'd4);
    chk("full_addr_wrap", 32'(mem_addr), 32'd0);
    chk("full_ready", 32'(in_ready), 32'd0);
    raw = 32'hA0000004; fmt = 2'b11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_5th_we", 32'(mem_we), 32'd0);
    chk("full_5th_count", 32'(count), 32'd4);

    // Abort during WRITE of the fourth word
    pulse_start();
    chk("abort_full_cleared", 32'(full_err), 32'd0);
    for (int i = 0; i < 3; i++)
      send(2'b11, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'hB0 + 32'(i), 1'b0);
    @(negedge clk);
    fmt = 2'b11; raw = 32'hB3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; start = 1'b1;
    #1;
    chk("abort_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    send(2'b11, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'hC0C0C0C0, 1'b0);
    chk("abort_next_addr", 32'(mem_addr), 32'd0);
    chk("abort_next_wdata", mem_wdata, 32'hC0C0C0C0);

    // Async reset in the middle of WRITE
    pulse_start();
    send(2'b11, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'h12345678, 1'b0);
    chk("rst_pre_we", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset("async_rst");
    @(negedge clk); rst = 1'b0;

    // Random round trip, sessions of three words
    for (int k = 0; k < 200; k++) begin
      if (k % 3 == 0) pulse_start();
      f = 2'($urandom_range(0, 3)); op = 6'($urandom); s = 5'($urandom); t = 5'($urandom);
      d = 5'($urandom); sh = 5'($urandom); fn = 6'($urandom); im = 16'($urandom);
      tg = 26'($urandom); rw = $urandom; lst = (k % 3 == 2);
      send(f, op, s, t, d, sh, fn, im, tg, rw, lst);
      w = mem_wdata;
      chk("rt_we", 32'(mem_we), 32'd1);
      chk("rt_addr", 32'(mem_addr), 32'(k % 3));
      chk("rt_word", w, model_pack(f, op, s, t, d, sh, fn, im, tg, rw));
      if (f != 2'b11) chk("rt_opcode", 32'(w[31:26]), 32'(op));
      if (f == 2'b00 || f == 2'b01) begin
        chk("rt_rs", 32'(w[25:21]), 32'(s));
        chk("rt_rt", 32'(w[20:16]), 32'(t));
      end
      if (f == 2'b00) begin
        chk("rt_rd", 32'(w[15:11]), 32'(d));
        chk("rt_shamt", 32'(w[10:6]), 32'(sh));
        chk("rt_funct", 32'(w[5:0]), 32'(fn));
      end
      if (f == 2'b01) chk("rt_imm", 32'(w[15:0]), 32'(im));
      if (f == 2'b10) chk("rt_target", 32'(w[25:0]), 32'(tg));
      if (f == 2'b11) chk("rt_raw", w, rw);
    end
    @(negedge clk);
    chk("rt_final_done", 32'(done), 32'd0);
    chk("rt_final_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
